// File: rtl/median_pkg.sv
// Shared types and helpers for the 3x3 median window controller.
package median_pkg;

  localparam int H_ACT_DEF = 320;
  localparam int V_ACT_DEF = 240;

  typedef logic [23:0] pixel_t;
  typedef pixel_t win_t [0:8];

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} mstate_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/median_line_buf.sv
// Single-line pixel store: one write port, one synchronous read port,
// read returns the old word when reading and writing the same address.
module median_line_buf
  import median_pkg::*;
#(
  parameter int DEPTH = H_ACT_DEF,
  parameter int DW    = 24,
  localparam int AW   = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The read register doubles as a window column, so it holds between beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/median_window_ctrl.sv
// Raster controller for an external 3x3 median filter: line buffers, window
// register, border pass-through selection and an end-of-frame flush.
module median_window_ctrl
  import median_pkg::*;
#(
  parameter int H_ACT = H_ACT_DEF,
  parameter int V_ACT = V_ACT_DEF,
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sof,
  input  logic [DW-1:0] in_pixel,
  output logic [DW-1:0] win_pix [0:8],
  input  logic [DW-1:0] med_in,
  output logic          out_valid,
  output logic [DW-1:0] out_pixel,
  output logic          out_sof,
  output logic          out_eof
);

  localparam int CW = cnt_w(H_ACT);
  localparam int RW = cnt_w(V_ACT);
  localparam int FW = cnt_w(H_ACT + 1);

  localparam logic [CW-1:0] COL_LAST       = CW'(H_ACT - 1);
  localparam logic [CW-1:0] COL_INNER_LAST = CW'(H_ACT - 2);
  localparam logic [CW-1:0] COL_ONE        = CW'(1);
  localparam logic [RW-1:0] ROW_LAST       = RW'(V_ACT - 1);
  localparam logic [RW-1:0] ROW_INNER_LAST = RW'(V_ACT - 2);
  localparam logic [RW-1:0] ROW_ONE        = RW'(1);
  localparam logic [FW-1:0] FLUSH_LAST     = FW'(H_ACT);

  mstate_e       state, state_nx;
  logic          accept, beat, sof_beat, produce;
  logic [DW-1:0] beat_pix;
  logic [CW-1:0] col, beat_col, col_nx, prev_col;
  logic [RW-1:0] row;
  logic [FW-1:0] fcnt;
  logic [CW-1:0] cx;
  logic [RW-1:0] cy;
  logic          en_frame;

  logic [DW-1:0] lb1_rd, lb2_rd, pix_r;
  logic [DW-1:0] col_l [0:2];
  logic [DW-1:0] col_m [0:2];

  logic          prod_d, pick_med_d, sof_d, eof_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx != FLUSH);
    end
  end

  // A FLUSH cycle is a beat of its own, carrying zero data.
  always_comb begin
    state_nx = state;
    accept   = in_valid & in_ready;
    beat     = 1'b0;
    sof_beat = 1'b0;
    produce  = 1'b0;
    beat_pix = in_pixel;
    case (state)
      IDLE: begin
        if (accept && in_sof) begin
          beat     = 1'b1;
          sof_beat = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          beat = 1'b1;
          if (in_sof) begin
            sof_beat = 1'b1;
          end else begin
            produce = (row > ROW_ONE) || (row == ROW_ONE && col != '0);
            if (row == ROW_LAST && col == COL_LAST) state_nx = FLUSH;
          end
        end
      end
      FLUSH: begin
        beat     = 1'b1;
        produce  = 1'b1;
        beat_pix = '0;
        if (fcnt == FLUSH_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign beat_col = sof_beat ? '0 : col;
  assign col_nx   = (beat_col == COL_LAST) ? '0 : beat_col + COL_ONE;

  // cx/cy track the center pixel of the window each producing beat emits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col      <= '0;
      prev_col <= '0;
      row      <= '0;
      fcnt     <= '0;
      cx       <= '0;
      cy       <= '0;
      en_frame <= 1'b0;
    end else begin
      if (beat) begin
        col      <= col_nx;
        prev_col <= beat_col;
      end
      if (sof_beat) row <= '0;
      else if (beat && state == RUN && col == COL_LAST) row <= row + ROW_ONE;
      fcnt <= (state == FLUSH) ? fcnt + FW'(1) : '0;
      if (sof_beat) en_frame <= en;
      if (sof_beat) begin
        cx <= '0;
        cy <= '0;
      end else if (produce) begin
        if (cx == COL_LAST) begin
          cx <= '0;
          cy <= cy + ROW_ONE;
        end else begin
          cx <= cx + COL_ONE;
        end
      end
    end
  end

  // lb2 is written one beat late: its data is lb1's registered read of the
  // previous column, which only becomes available after that beat.
  median_line_buf #(.DEPTH(H_ACT), .DW(DW)) lb1 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (beat),
    .wr_addr (beat_col),
    .wr_data (beat_pix),
    .rd_en   (beat),
    .rd_addr (beat_col),
    .rd_data (lb1_rd)
  );

  median_line_buf #(.DEPTH(H_ACT), .DW(DW)) lb2 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (beat),
    .wr_addr (prev_col),
    .wr_data (lb1_rd),
    .rd_en   (beat),
    .rd_addr (beat_col),
    .rd_data (lb2_rd)
  );

  // Right window column is {lb2_rd, lb1_rd, pix_r}; the other two shift in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_r <= '0;
      for (int r = 0; r < 3; r++) begin
        col_l[r] <= '0;
        col_m[r] <= '0;
      end
    end else if (beat) begin
      pix_r    <= beat_pix;
      col_l[0] <= col_m[0];
      col_l[1] <= col_m[1];
      col_l[2] <= col_m[2];
      col_m[0] <= lb2_rd;
      col_m[1] <= lb1_rd;
      col_m[2] <= pix_r;
    end
  end

  assign win_pix[0] = col_l[0];
  assign win_pix[1] = col_m[0];
  assign win_pix[2] = lb2_rd;
  assign win_pix[3] = col_l[1];
  assign win_pix[4] = col_m[1];
  assign win_pix[5] = lb1_rd;
  assign win_pix[6] = col_l[2];
  assign win_pix[7] = col_m[2];
  assign win_pix[8] = pix_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_d     <= 1'b0;
      pick_med_d <= 1'b0;
      sof_d      <= 1'b0;
      eof_d      <= 1'b0;
    end else begin
      prod_d     <= produce;
      pick_med_d <= produce && en_frame &&
                    cx != '0 && cx <= COL_INNER_LAST &&
                    cy != '0 && cy <= ROW_INNER_LAST;
      sof_d      <= produce && cx == '0 && cy == '0;
      eof_d      <= produce && cx == COL_LAST && cy == ROW_LAST;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_pixel <= '0;
    end else begin
      out_valid <= prod_d;
      out_sof   <= sof_d;
      out_eof   <= eof_d;
      if (prod_d) out_pixel <= pick_med_d ? med_in : col_m[1];
    end
  end

endmodule

// File: tb/tb_median_window_ctrl.sv
// Self-checking bench for median_window_ctrl on an 8x6 frame, with a
// behavioural median filter attached and a frame-level reference model.
module tb_median_window_ctrl;
  import median_pkg::*;

  localparam int H  = 8;
  localparam int V  = 6;
  localparam int N  = H * V;
  localparam int DW = 24;

  logic   clk = 1'b0;
  logic   reset, en, in_valid, in_ready, in_sof;
  logic   out_valid, out_sof, out_eof;
  pixel_t in_pixel, med_in, out_pixel;
  win_t   win_pix;

  int n_pass = 0;
  int n_checks = 0;
  int cyc = 0;

  pixel_t frame [0:N-1];
  int     beat_cyc [0:N-1];
  pixel_t q_pix [$];
  bit     q_sof [$];
  bit     q_eof [$];
  int     q_cyc [$];

  median_window_ctrl #(.H_ACT(H), .V_ACT(V), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_pixel  (in_pixel),
    .win_pix   (win_pix),
    .med_in    (med_in),
    .out_valid (out_valid),
    .out_pixel (out_pixel),
    .out_sof   (out_sof),
    .out_eof   (out_eof)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic pixel_t med9(input win_t v);
    pixel_t r = '0;
    int c [9];
    int t;
    for (int ch = 0; ch < 3; ch++) begin
      for (int i = 0; i < 9; i++) c[i] = int'(v[i][ch*8 +: 8]);
      for (int i = 0; i < 9; i++)
        for (int j = 0; j < 8 - i; j++)
          if (c[j] > c[j+1]) begin
            t = c[j]; c[j] = c[j+1]; c[j+1] = t;
          end
      r[ch*8 +: 8] = 8'(c[4]);
    end
    return r;
  endfunction

  assign med_in = med9(win_pix);

  function automatic pixel_t ref_out(input int n, input bit en_f);
    int   x = n % H;
    int   y = n / H;
    win_t v;
    if (en_f && x >= 1 && x <= H - 2 && y >= 1 && y <= V - 2) begin
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++)
          v[(dy + 1) * 3 + dx + 1] = frame[(y + dy) * H + x + dx];
      return med9(v);
    end
    return frame[n];
  endfunction

  // Cycle in which output n should be visible: two cycles after its beat.
  function automatic int exp_cyc(input int n);
    if (n + H + 1 <= N - 1) return beat_cyc[n + H + 1] + 2;
    return beat_cyc[N - 1] + (n - (N - H - 1)) + 3;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1) begin
      q_pix.push_back(out_pixel);
      q_sof.push_back(out_sof);
      q_eof.push_back(out_eof);
      q_cyc.push_back(cyc);
    end
  end

  task automatic clear_queues();
    q_pix.delete(); q_sof.delete(); q_eof.delete(); q_cyc.delete();
  endtask

  task automatic applyStimulus(input int nbeats, input int gap_pct, input bit en_val, input bit toggle_en);
    int  c, waited;
    bit  acc;
    for (int k = 0; k < nbeats; k++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_sof   = (k == 0);
      in_pixel = frame[k];
      en       = (k == 0 || !toggle_en) ? en_val : 1'($urandom_range(1));
      waited   = 0;
      do begin
        c   = cyc;
        acc = in_ready;
        @(posedge clk); #1;
        waited++;
      end while (!acc && waited < 200);
      if (!acc) begin
        checkOutput("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      beat_cyc[k] = c;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain(output int low);
    low = 0;
    repeat (24) begin
      @(negedge clk);
      if (!in_ready) low++;
    end
  endtask

  task automatic check_frame(input int base, input bit en_f, input string name);
    checkOutput({name, "/count"}, q_pix.size() - base, N);
    for (int n = 0; n < N && base + n < q_pix.size(); n++) begin
      checkOutput($sformatf("%s/pix[%0d]", name, n), q_pix[base + n], ref_out(n, en_f));
      checkOutput($sformatf("%s/sof[%0d]", name, n), q_sof[base + n], n == 0);
      checkOutput($sformatf("%s/eof[%0d]", name, n), q_eof[base + n], n == N - 1);
      checkOutput($sformatf("%s/lat[%0d]", name, n), q_cyc[base + n], exp_cyc(n));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int low, sof2, eofs;
    reset = 1'b1; en = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset/in_ready", in_ready, 0);
    checkOutput("reset/out_valid", out_valid, 0);
    checkOutput("reset/out_pixel", out_pixel, 0);
    checkOutput("reset/win_center", win_pix[4], 0);
    checkOutput("reset/out_sof_eof", {out_sof, out_eof}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] ramp frame");
    for (int k = 0; k < N; k++) frame[k] = 24'(k) * 24'h010101;
    clear_queues();
    applyStimulus(N, 0, 1'b1, 1'b0);
    drain(low);
    check_frame(0, 1'b1, "ramp");
    checkOutput("ramp/flush_ready_low", low, H + 1);
    checkOutput("ramp/first_latency", q_cyc[0] - beat_cyc[0], H + 3);

    $display("[TB] impulse frame");
    for (int k = 0; k < N; k++) frame[k] = 24'h101010;
    frame[2*H + 3] = 24'hFFFFFF;
    frame[2*H + 0] = 24'hFFFFFF;
    clear_queues();
    applyStimulus(N, 0, 1'b1, 1'b0);
    drain(low);
    check_frame(0, 1'b1, "impulse");
    checkOutput("impulse/interior_removed", q_pix[2*H + 3], 24'h101010);
    checkOutput("impulse/border_kept", q_pix[2*H + 0], 24'hFFFFFF);

    $display("[TB] bypass frame, enable toggled mid-frame");
    clear_queues();
    applyStimulus(N, 0, 1'b0, 1'b1);
    drain(low);
    check_frame(0, 1'b0, "bypass");
    checkOutput("bypass/impulse_kept", q_pix[2*H + 3], 24'hFFFFFF);

    $display("[TB] random frame with input gaps");
    for (int k = 0; k < N; k++) frame[k] = 24'($urandom);
    clear_queues();
    applyStimulus(N, 50, 1'b1, 1'b0);
    drain(low);
    check_frame(0, 1'b1, "gaps");
    checkOutput("gaps/flush_ready_low", low, H + 1);
    checkOutput("gaps/idle_after", 32'(dut.state), 32'(IDLE));
    checkOutput("gaps/ready_after", in_ready, 1);

    $display("[TB] frame aborted by a new SOF");
    for (int k = 0; k < N; k++) frame[k] = 24'($urandom);
    clear_queues();
    applyStimulus(20, 0, 1'b1, 1'b0);
    for (int k = 0; k < N; k++) frame[k] = 24'($urandom);
    applyStimulus(N, 0, 1'b1, 1'b0);
    drain(low);
    sof2 = -1;
    eofs = 0;
    for (int i = 0; i < q_pix.size(); i++) begin
      if (i > 0 && q_sof[i] && sof2 < 0) sof2 = i;
      if (q_eof[i]) eofs++;
    end
    checkOutput("abort/first_sof", q_sof[0], 1);
    checkOutput("abort/frame1_outputs", sof2, 20 - (H + 1));
    checkOutput("abort/eof_count", eofs, 1);
    check_frame(20 - (H + 1), 1'b1, "abort");

    $display("[TB] reset mid-frame");
    for (int k = 0; k < N; k++) frame[k] = 24'($urandom);
    clear_queues();
    applyStimulus(31, 0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset/out_valid", out_valid, 0);
    checkOutput("midreset/out_pixel", out_pixel, 0);
    checkOutput("midreset/win_center", win_pix[4], 0);
    checkOutput("midreset/in_ready", in_ready, 0);
    checkOutput("midreset/state", 32'(dut.state), 32'(IDLE));
    @(posedge clk); #1;
    reset = 1'b0;
    clear_queues();
    for (int k = 0; k < N; k++) frame[k] = 24'($urandom);
    applyStimulus(N, 0, 1'b1, 1'b0);
    drain(low);
    check_frame(0, 1'b1, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/median_window_ctrl.md
Name: median_window_ctrl

Overview:
- Streaming controller that sequences the combinational 3x3 median filter over a raster frame from the camera/VGA pixel path.
- Holds two line buffers and a 3x3 window shift register. Drives the nine window pixels to the filter and takes its median back.
- Outputs a registered, frame-aligned filtered pixel stream with border pass-through.
- A FLUSH state drains the final row and column after each frame.

Parameters:
- H_ACT, 320, active pixels per line.
- V_ACT, 240, active lines per frame.
- DW, 24, pixel width, RGB888 {R[23:16],G[15:8],B[7:0]}.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  filter enable; sampled only on an accepted SOF beat.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input can be accepted; low in FLUSH.
- in_sof  in  1  first pixel of frame, qualified by in_valid.
- in_pixel  in  DW  input pixel.
- win_pix  out  9xDW  window to filter, index r*3+c (r,c in 0..2), center at index 4.
- med_in  in  DW  median result returned combinationally by the filter.
- out_valid  out  1  output pixel valid (single-cycle strobe, no backpressure).
- out_pixel  out  DW  filtered or pass-through pixel.
- out_sof  out  1  high with the first output pixel of a frame.
- out_eof  out  1  high with the last output pixel of a frame.

Behaviour:
- Reset (async) values:
  - State is IDLE.
  - col, row and beat counters are 0.
  - in_ready, out_valid, out_sof and out_eof are 0.
  - out_pixel and win_pix are 0.
  - Line buffer RAM contents are not cleared.
- Beat definitions:
  - A beat is accepted when in_valid & in_ready.
  - beat index k is the raster index within the frame (0..H_ACT*V_ACT-1).
- States:
  - IDLE: in_ready=1. Beats without in_sof are dropped. An accepted in_sof beat latches en into en_frame, is processed as k=0, and moves to RUN.
  - RUN: in_ready=1. col wraps H_ACT-1→0 and increments row. Accepting k=H_ACT*V_ACT-1 moves to FLUSH.
  - FLUSH: in_ready=0. Inserts exactly H_ACT+1 internal beats, one per cycle, carrying don't-care data (zero), then returns to IDLE.
  - An in_sof beat accepted in RUN aborts the current frame with no flush and no out_eof. Counters restart with this beat as k=0 and en is re-latched.
  - Reset in any state returns to IDLE immediately; a partial frame is discarded.
- Line buffers:
  - lb1 holds row y-1 and lb2 holds row y-2, each H_ACT deep and addressed by col.
  - Read-before-write on the same address in the same cycle.
  - A FLUSH beat advances col and writes like a real beat.
- Window:
  - Every beat shifts the window one column: new right column = {lb2[col], lb1[col], pixel}.
  - Registered one cycle after the beat.
- Output mapping:
  - An output is produced for every beat with k >= H_ACT+1, plus every FLUSH beat.
  - This gives exactly H_ACT*V_ACT outputs per frame, for center index n = k-(H_ACT+1).
- Latency: out_valid is asserted exactly 2 cycles after the producing beat (beat → window reg → out reg).
- Output selection, for center coordinate (cx,cy):
  - out_pixel = med_in when en_frame=1 and 1<=cx<=H_ACT-2 and 1<=cy<=V_ACT-2.
  - Otherwise out_pixel = win_pix[4], the raw center, equal to the input pixel of raster index n.
  - Stale line-buffer data and wrapped columns only ever appear in border windows, so they are never selected.
- Frame markers: out_sof is asserted with n=0 and out_eof with n=H_ACT*V_ACT-1.
- A new in_sof is not accepted during FLUSH (in_ready=0); the upstream source holds it.
- Width: all comparisons and selection are per 8-bit channel inside the filter. The controller performs no arithmetic on pixel data.

Decomposition:
- Package median_pkg:
  - localparams H_ACT_DEF=320 and V_ACT_DEF=240.
  - typedef logic [23:0] pixel_t.
  - typedef pixel_t win_t [0:8].
  - typedef enum logic [1:0] {IDLE, RUN, FLUSH} mstate_e.
  - Counter width function via $clog2.
- Sub-module median_line_buf:
  - Parameters DEPTH and DW.
  - One write port and one read port, synchronous read, read-before-write.
  - Instantiated twice (lb1, lb2) so it maps to BRAM.
- The filter itself stays external, connected through win_pix and med_in.

Test Plan:
- H_ACT=8, V_ACT=6, en=1, ramp frame pixel=k*0x010101: every output equals its input (median of a linear 3x3 ramp equals the center). Exactly 48 out_valid, out_sof at n=0, out_eof at n=47, 2-cycle latency from each producing beat.
- Same frame with a single impulse 0xFFFFFF at (3,2) on a 0x101010 background: output at (3,2) is 0x101010. An impulse at (0,2) (border) passes through as 0xFFFFFF.
- en=0 latched at SOF with the impulse frame: output stream is identical to the input delayed by H_ACT+1 beats, 48 outputs. Toggling en mid-frame has no effect.
- Random in_valid gaps (~50% duty): output values are unchanged versus the gapless run. in_ready=0 for exactly 9 cycles in FLUSH, then IDLE.
- in_sof reasserted at k=20 of frame 1: no out_eof for frame 1. Frame 2 yields 48 correct outputs starting with out_sof.
- Reset asserted mid-RUN at k=30 for 1 cycle: all outputs go 0 asynchronously and state is IDLE. The next SOF frame is filtered correctly despite stale line buffers.
